// File: rtl/game_ctrl_pkg.sv
// Shared state codes and width helpers for the snake game-flow controller.
package game_ctrl_pkg;

  localparam int GS_W = 3;

  localparam logic [GS_W-1:0] ST_RESTART = 3'd0;
  localparam logic [GS_W-1:0] ST_START   = 3'd1;
  localparam logic [GS_W-1:0] ST_PLAY    = 3'd2;
  localparam logic [GS_W-1:0] ST_DIE     = 3'd3;
  localparam logic [GS_W-1:0] ST_OVER    = 3'd4;
  localparam logic [GS_W-1:0] ST_PAUSE   = 3'd5;

  function automatic int die_cycles(input int half, input int toggles);
    return half * (toggles + 2);
  endfunction

  function automatic int lives_width(input int lives);
    return $clog2(lives + 1);
  endfunction

  // The counter also times RESTART, so make sure that count fits too.
  function automatic int cnt_width(input int die, input int rst_cycles);
    int w;
    int r;
    w = $clog2(die);
    r = $clog2(rst_cycles + 1);
    if (r > w) w = r;
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/game_ctrl_fsm_if.sv
// Key/collision inputs and status outputs of the game-flow controller.
interface game_ctrl_fsm_if #(
  parameter int NUM_KEYS = 4,
  parameter int LIVES_W  = 2
);
  import game_ctrl_pkg::*;

  logic [NUM_KEYS-1:0] key_press;
  logic                pause_key;
  logic                hit_wall;
  logic                hit_body;
  logic [GS_W-1:0]     game_status;
  logic                die_flash;
  logic                restart;
  logic [LIVES_W-1:0]  lives_left;
  logic                game_over;

  modport master (
    output key_press, pause_key, hit_wall, hit_body,
    input  game_status, die_flash, restart, lives_left, game_over
  );

  modport slave (
    input  key_press, pause_key, hit_wall, hit_body,
    output game_status, die_flash, restart, lives_left, game_over
  );
endinterface

// File: rtl/game_ctrl_fsm_flash_timer.sv
// Shared DIE/RESTART/PAUSE counter with a half-period phase strobe and terminal flag.
module flash_timer #(
  parameter int HALF = 4,
  parameter int TERM = 32,
  parameter int CW   = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          run,
  output logic [CW-1:0] cnt,
  output logic          strobe,
  output logic          term
);
  localparam int PW = (HALF > 1) ? $clog2(HALF) : 1;

  // Separate phase counter avoids a modulo on cnt for non-power-of-2 HALF.
  logic [PW-1:0] ph;
  logic          ph_last;

  assign ph_last = (ph == PW'(HALF - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      ph  <= '0;
    end else if (clr) begin
      cnt <= '0;
      ph  <= '0;
    end else if (run) begin
      cnt <= cnt + 1'b1;
      ph  <= ph_last ? '0 : ph + 1'b1;
    end
  end

  assign strobe = ph_last;
  assign term   = (cnt == CW'(TERM - 1));
endmodule

// File: rtl/game_ctrl_fsm.sv
// Snake game-flow FSM: START/PLAY/DIE/RESTART/OVER with lives and flash timing.
// Optional PAUSE state is built when GAME_CTRL_PAUSE_EN is defined.
module game_ctrl_fsm
  import game_ctrl_pkg::*;
#(
  parameter int NUM_KEYS          = 4,
  parameter int LIVES             = 3,
  parameter int RESTART_CYCLES    = 6,
  parameter int FLASH_HALF_CYCLES = 25_000_000,
  parameter int FLASH_TOGGLES     = 6
) (
  input logic          CLK_50M,
  input logic          RST,
  game_ctrl_fsm_if.slave bus
);
  localparam int LIVES_W    = lives_width(LIVES);
  localparam int DIE_CYCLES = die_cycles(FLASH_HALF_CYCLES, FLASH_TOGGLES);
  localparam int CW         = cnt_width(DIE_CYCLES, RESTART_CYCLES);
  localparam int FLASH_END  = FLASH_HALF_CYCLES * FLASH_TOGGLES;

  logic [GS_W-1:0]     state, state_d;
  logic                flash, flash_d;
  logic                restart, restart_d;
  logic [LIVES_W-1:0]  lives, lives_d;
  logic                over, over_d;

  logic [NUM_KEYS-1:0] keys;
  logic                any_key, hit, run, clr;
  logic [CW-1:0]       cnt;
  logic                strobe, term;

  assign keys    = bus.key_press;
  assign any_key = |keys;
  assign hit     = bus.hit_wall | bus.hit_body;

`ifndef GAME_CTRL_PAUSE_EN
  logic unused_pause;
  assign unused_pause = bus.pause_key;
`endif

  always_comb begin
    state_d   = state;
    flash_d   = flash;
    restart_d = restart;
    lives_d   = lives;
    over_d    = over;
    case (state)
      ST_START: if (any_key) state_d = ST_PLAY;
      ST_PLAY: begin
        if (hit) begin
          state_d = ST_DIE;
          if (lives != '0) lives_d = lives - 1'b1;
        end
`ifdef GAME_CTRL_PAUSE_EN
        else if (bus.pause_key) state_d = ST_PAUSE;
`endif
      end
      ST_DIE: begin
        if (term) begin
          flash_d = 1'b1;
          state_d = (lives != '0) ? ST_RESTART : ST_OVER;
          over_d  = (lives == '0);
        end else if (strobe && (cnt < CW'(FLASH_END))) begin
          flash_d = ~flash;
        end
      end
      ST_RESTART: begin
        if (cnt == CW'(RESTART_CYCLES)) begin
          restart_d = 1'b0;
          state_d   = ST_START;
        end else begin
          restart_d = 1'b1;
        end
      end
      ST_OVER: begin
        over_d  = 1'b1;
        flash_d = 1'b1;
        if (any_key) begin
          state_d = ST_RESTART;
          lives_d = LIVES_W'(LIVES);
          over_d  = 1'b0;
        end
      end
`ifdef GAME_CTRL_PAUSE_EN
      ST_PAUSE: begin
        if (bus.pause_key) begin
          state_d = ST_PLAY;
          flash_d = 1'b1;
        end else if (strobe) begin
          flash_d = ~flash;
        end
      end
`endif
      default: begin
        state_d   = ST_START;
        flash_d   = 1'b1;
        restart_d = 1'b0;
        over_d    = 1'b0;
      end
    endcase
  end

  // Counter only advances while staying in a timed state; any exit clears it.
  always_comb begin
    run = 1'b0;
    if (state_d == state) begin
      case (state)
        ST_DIE, ST_RESTART: run = 1'b1;
`ifdef GAME_CTRL_PAUSE_EN
        ST_PAUSE:           run = 1'b1;
`endif
        default:            run = 1'b0;
      endcase
    end
  end
  assign clr = ~run;

  flash_timer #(
    .HALF (FLASH_HALF_CYCLES),
    .TERM (DIE_CYCLES),
    .CW   (CW)
  ) u_timer (
    .clk    (CLK_50M),
    .rst    (RST),
    .clr    (clr),
    .run    (run),
    .cnt    (cnt),
    .strobe (strobe),
    .term   (term)
  );

  always_ff @(posedge CLK_50M or posedge RST) begin
    if (RST) begin
      state   <= ST_START;
      flash   <= 1'b1;
      restart <= 1'b0;
      lives   <= LIVES_W'(LIVES);
      over    <= 1'b0;
    end else begin
      state   <= state_d;
      flash   <= flash_d;
      restart <= restart_d;
      lives   <= lives_d;
      over    <= over_d;
    end
  end

  assign bus.game_status = state;
  assign bus.die_flash   = flash;
  assign bus.restart     = restart;
  assign bus.lives_left  = lives;
  assign bus.game_over   = over;
endmodule

// File: tb/tb_game_ctrl_fsm.sv
// Scoreboard bench for game_ctrl_fsm: stimulus queues per-cycle expectations, a negedge monitor checks them.
module tb_game_ctrl_fsm;
  localparam logic [2:0] S_RESTART = 3'd0, S_START = 3'd1, S_PLAY = 3'd2,
                         S_DIE = 3'd3, S_OVER = 3'd4, S_PAUSE = 3'd5;

  typedef struct packed {
    logic [2:0] st;
    logic       fl;
    logic       rs;
    logic [1:0] lv;
    logic       go;
  } snap_t;

  typedef struct {
    int    cyc;
    string tag;
    snap_t s;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] keys = '0;
  logic       pause = 1'b0, hw = 1'b0, hb = 1'b0;
  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;
  exp_t       q[$];

  game_ctrl_fsm_if #(.NUM_KEYS(4), .LIVES_W(2)) bus();

  assign bus.key_press = keys;
  assign bus.pause_key = pause;
  assign bus.hit_wall  = hw;
  assign bus.hit_body  = hb;

  game_ctrl_fsm #(
    .NUM_KEYS(4), .LIVES(2), .RESTART_CYCLES(6),
    .FLASH_HALF_CYCLES(4), .FLASH_TOGGLES(6)
  ) dut (
    .CLK_50M (clk),
    .RST     (rst),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare the DUT snapshot against the head of the queue.
  exp_t  mon_e;
  snap_t act;
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].cyc <= cyc) begin
      mon_e = q.pop_front();
      act   = '{bus.game_status, bus.die_flash, bus.restart, bus.lives_left, bus.game_over};
      tests++;
      if (mon_e.cyc != cyc || act !== mon_e.s) begin
        fails++;
        $display("FAIL %s cyc=%0d: got st=%0d flash=%0b restart=%0b lives=%0d over=%0b, want st=%0d flash=%0b restart=%0b lives=%0d over=%0b",
                 mon_e.tag, cyc, act.st, act.fl, act.rs, act.lv, act.go,
                 mon_e.s.st, mon_e.s.fl, mon_e.s.rs, mon_e.s.lv, mon_e.s.go);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [2:0] st, input logic fl,
                     input logic rs, input logic [1:0] lv, input logic go);
    exp_t e;
    e.cyc = cyc;
    e.tag = tag;
    e.s   = '{st, fl, rs, lv, go};
    q.push_back(e);
  endtask

  // Flash level at DIE count c: toggles at 4,8,..,24, starting from 1.
  function automatic logic die_flash_at(input int c);
    int t;
    t = c / 4;
    if (t > 6) t = 6;
    return (t % 2) == 0;
  endfunction

  // Steps DIE counts 1..last; keys and a body hit at count 10 must be ignored.
  task automatic die_run(input string tag, input logic [1:0] lv, input int last);
    for (int c = 1; c <= last; c++) begin
      if (c == 10) begin
        hb   = 1'b1;
        keys = 4'b1111;
      end
      step();
      hb   = 1'b0;
      keys = '0;
      chk(tag, S_DIE, die_flash_at(c), 1'b0, lv, 1'b0);
    end
  endtask

  task automatic restart_run(input string tag, input logic [1:0] lv);
    repeat (6) begin
      step();
      chk(tag, S_RESTART, 1'b1, 1'b1, lv, 1'b0);
    end
    step();
    chk({tag, "_done"}, S_START, 1'b1, 1'b0, lv, 1'b0);
  endtask

  initial begin
    step(); chk("reset", S_START, 1, 0, 2, 0);
    rst = 1'b0;
    step(); chk("idle", S_START, 1, 0, 2, 0);

    hw = 1; step(); hw = 0; chk("start_ign_hit", S_START, 1, 0, 2, 0);
    keys = 4'b0100; step(); keys = '0; chk("start_to_play", S_PLAY, 1, 0, 2, 0);

    // First death: one life left, then restart.
    hw = 1; step(); hw = 0; chk("die1_entry", S_DIE, 1, 0, 1, 0);
    die_run("die1", 2'd1, 31);
    step(); chk("die1_exit", S_RESTART, 1, 0, 1, 0);
    restart_run("restart1", 2'd1);

    // Second death: out of lives, game over.
    keys = 4'b0001; step(); keys = '0; chk("play2", S_PLAY, 1, 0, 1, 0);
    hb = 1; step(); hb = 0; chk("die2_entry", S_DIE, 1, 0, 0, 0);
    die_run("die2", 2'd0, 31);
    step(); chk("over", S_OVER, 1, 0, 0, 1);
    hw = 1; step(); hw = 0; chk("over_hold", S_OVER, 1, 0, 0, 1);
    keys = 4'b1000; step(); keys = '0; chk("over_key", S_RESTART, 1, 0, 2, 0);
    restart_run("restart2", 2'd2);

    // Collision and pause together: collision wins.
    keys = 4'b0010; step(); keys = '0; chk("play3", S_PLAY, 1, 0, 2, 0);
    hw = 1; pause = 1; step(); hw = 0; pause = 0; chk("tie_die", S_DIE, 1, 0, 1, 0);
    die_run("die3", 2'd1, 9);
    step();
    rst = 1'b1;
    chk("rst_mid_die", S_START, 1, 0, 2, 0);
    step(); rst = 1'b0; chk("rst_hold", S_START, 1, 0, 2, 0);
    keys = 4'b0001; step(); keys = '0; chk("fresh_play", S_PLAY, 1, 0, 2, 0);

`ifdef GAME_CTRL_PAUSE_EN
    pause = 1; step(); pause = 0; chk("pause_entry", S_PAUSE, 1, 0, 2, 0);
    for (int j = 1; j <= 6; j++) begin
      if (j == 2) hw = 1;
      if (j == 5) keys = 4'b0100;
      step();
      hw = 0; keys = '0;
      chk("pause_run", S_PAUSE, ((j / 4) % 2) == 0, 0, 2, 0);
    end
    pause = 1; step(); pause = 0; chk("pause_exit", S_PLAY, 1, 0, 2, 0);
`else
    pause = 1; step(); pause = 0; chk("pause_ignored", S_PLAY, 1, 0, 2, 0);
`endif

    hw = 1; step(); hw = 0; chk("play_die_again", S_DIE, 1, 0, 1, 0);
    repeat (3) step();

    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL queue_drain: %0d expectations left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
